// File: rtl/rom_byte_streamer_if.sv
// Control, ROM and stream signals of the ROM byte streamer, bundled for port
// connection. "master" is the streamer side (it owns the ROM address and the
// output stream); "slave" is the surrounding host/ROM/consumer side.
interface rom_byte_streamer_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int LEN_BITS  = ADDR_BITS + 1
);
  // transfer request
  logic                 start;
  logic                 abort;
  logic [ADDR_BITS-1:0] base_addr;
  logic [LEN_BITS-1:0]  length;
  // combinational ROM port
  logic [ADDR_BITS-1:0] rom_addr;
  logic [DATA_BITS-1:0] rom_data;
  // output stream and status
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, base_addr, length, rom_data, out_ready,
    output rom_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, abort, base_addr, length, rom_data, out_ready,
    input  rom_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/rom_byte_streamer.sv
// Walks a contiguous range of a combinational-read ROM and presents each word
// on a valid/ready stream at one word per cycle. The ROM address register
// always points at the word that will be captured next, so the registered
// output can be refilled on the same edge that the consumer accepts a word.
module rom_byte_streamer #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int LEN_BITS  = ADDR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rom_byte_streamer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  remaining;
  logic [DATA_BITS-1:0] data_p1;
  logic                 vld_p1;
  logic                 last_p1;
  logic                 busy_q;
  logic                 done_q;
  logic                 hs;

  // Address advance wraps naturally modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
    return a + ADDR_BITS'(1);
  endfunction

  // The word being captured is the final one when only it is left to fetch.
  function automatic logic is_last(input logic [LEN_BITS-1:0] rem);
    return rem == LEN_BITS'(1);
  endfunction

  assign hs            = vld_p1 & bus.out_ready;
  assign bus.rom_addr  = addr_q;
  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Sequencer FSM, address/length counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // abort has priority over a simultaneous start
          if (bus.start && !bus.abort) begin
            if (bus.length != '0) begin
              addr_q    <= bus.base_addr;
              remaining <= bus.length;
              busy_q    <= 1'b1;
              state     <= LOAD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.abort) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            // stage p1: first ROM word captured into the output register
            data_p1   <= bus.rom_data;
            vld_p1    <= 1'b1;
            last_p1   <= is_last(remaining);
            addr_q    <= next_addr(addr_q);
            remaining <= remaining - LEN_BITS'(1);
            state     <= SEND;
          end
        end

        SEND: begin
          if (bus.abort) begin
            // a handshake in this cycle is still accepted, but no done
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (hs) begin
            if (remaining != '0) begin
              // stage p1: refill on the accepting edge, no bubble
              data_p1   <= bus.rom_data;
              last_p1   <= is_last(remaining);
              addr_q    <= next_addr(addr_q);
              remaining <= remaining - LEN_BITS'(1);
            end else begin
              vld_p1  <= 1'b0;
              last_p1 <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        default: begin
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
